serial_alu_sequencer: RTL and testbench

- Bit-serial ALU front end that drives one external single-bit ALU slice.
- Each cycle it presents one operand bit pair and the chained carry-in, then captures the slice's sum and carry-out.
- It builds a WIDTH-bit result and the flags over WIDTH cycles.
- Used where area matters more than latency, e.g. a low-cost execute path or a BIST check of a slice against the full parallel ALU.

---
 rtl/serial_alu_sequencer.sv | 161 ++++++++++++++++
 tb/tb_serial_alu_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU sequencer: walks one external single-bit slice across WIDTH
// bit positions, chaining the carry and assembling result plus flags.
module serial_alu_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       cntrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic [2:0]       slice_sel,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    input  logic             slice_sum,
    input  logic             slice_cout
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             cout_q, cout_d;

    logic arith;
    logic legal;
    logic last;

    assign arith = (op_q == 3'b010) || (op_q == 3'b011);
    assign legal = (op_q != 3'b001) && (op_q != 3'b111);
    assign last  = (idx_q == IW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'b000;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            cout_q   <= cout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        neg_d     = neg_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        cout_d    = cout_q;
        slice_sel = 3'b000;
        slice_a   = 1'b0;
        slice_b   = 1'b0;
        slice_cin = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    op_d     = cntrl;
                    idx_d    = '0;
                    carry_d  = (cntrl == 3'b011);
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    result_d = '0;
                    neg_d    = 1'b0;
                    zero_d   = 1'b1;
                    ovf_d    = 1'b0;
                    cout_d   = 1'b0;
                end
            end
            RUN: begin
                slice_sel        = op_q;
                slice_a          = a_q[idx_q];
                slice_b          = b_q[idx_q];
                slice_cin        = arith & carry_q;
                // Illegal codes still step through every bit, capturing zeros.
                result_d[idx_q]  = legal & slice_sum;
                carry_d          = slice_cout;
                idx_d            = idx_q + IW'(1);
                if (last) begin
                    cout_d  = arith & slice_cout;
                    ovf_d   = arith & (carry_q ^ slice_cout);
                    neg_d   = result_d[WIDTH-1];
                    zero_d  = (result_d == '0);
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign negative  = neg_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer with a behavioural one-bit slice.
module tb_serial_alu_sequencer;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   cntrl;
    logic [W-1:0] A, B;
    logic         busy, done;
    logic [W-1:0] result;
    logic         negative, zero, overflow, carry_out;
    logic [2:0]   slice_sel;
    logic         slice_a, slice_b, slice_cin;
    logic         slice_sum, slice_cout;

    int checks   = 0;
    int failures = 0;

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cntrl      (cntrl),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .negative   (negative),
        .zero       (zero),
        .overflow   (overflow),
        .carry_out  (carry_out),
        .slice_sel  (slice_sel),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout)
    );

    always #5 clk = ~clk;

    // Reference slice; illegal codes return ones so forcing to zero is visible.
    logic bn;
    always_comb begin
        slice_sum  = 1'b0;
        slice_cout = 1'b0;
        bn         = ~slice_b;
        case (slice_sel)
            3'b000: slice_sum = slice_b;
            3'b010: begin
                slice_sum  = slice_a ^ slice_b ^ slice_cin;
                slice_cout = (slice_a & slice_b) | (slice_a & slice_cin)
                           | (slice_b & slice_cin);
            end
            3'b011: begin
                slice_sum  = slice_a ^ bn ^ slice_cin;
                slice_cout = (slice_a & bn) | (slice_a & slice_cin)
                           | (bn & slice_cin);
            end
            3'b100: slice_sum = slice_a & slice_b;
            3'b101: slice_sum = slice_a | slice_b;
            3'b110: slice_sum = slice_a ^ slice_b;
            default: begin
                slice_sum  = 1'b1;
                slice_cout = 1'b1;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1;
        cntrl = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic en,
                         input logic ez, input logic eo, input logic ec);
        int n;
        start_op(op, a, b);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_sel0"}, 64'(slice_sel), 64'(op));
        chk({tag, "_ab0"}, 64'({slice_a, slice_b}), 64'({a[0], b[0]}));
        chk({tag, "_cin0"}, 64'(slice_cin), 64'(op == 3'b011));
        wait_done(n);
        chk({tag, "_lat"}, 64'(n), 64'(W));
        chk({tag, "_res"}, result, er);
        chk({tag, "_flags"}, 64'({negative, zero, overflow, carry_out}),
            64'({en, ez, eo, ec}));
        chk({tag, "_busy_dn"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
        chk({tag, "_hold"}, result, er);
    endtask

    logic [2:0]   lop [4] = '{3'b100, 3'b101, 3'b110, 3'b000};
    logic [W-1:0] lres[4] = '{64'hF000_0000_0000_0000,
                              64'hFFF0_F0F0_F0F0_F0F0,
                              64'h0FF0_F0F0_F0F0_F0F0,
                              64'hFF00_0000_0000_0000};
    logic         lneg[4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int n;
        int dn;
        reset = 1'b1;
        start = 1'b0;
        cntrl = 3'b000;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl", 64'({busy, done}), 64'd0);
        chk("rst_res", result, 64'd0);
        chk("rst_flags", 64'({negative, zero, overflow, carry_out}), 64'b0100);
        chk("rst_slice", 64'({slice_sel, slice_a, slice_b, slice_cin}), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op("add", 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
              64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        do_op("sub0", 3'b011, 64'd5, 64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        do_op("subn", 3'b011, 64'd0, 64'd1, '1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            do_op($sformatf("logic%0d", i), lop[i], 64'hF0F0_F0F0_F0F0_F0F0,
                  64'hFF00_0000_0000_0000, lres[i], lneg[i], 1'b0, 1'b0, 1'b0);

        // start held high through RUN; only the DONE-cycle request is taken
        @(negedge clk);
        start = 1'b1;
        cntrl = 3'b010;
        A     = 64'd1;
        B     = 64'd2;
        @(posedge clk);
        #1;
        cntrl = 3'b110;
        A     = 64'd100;
        B     = 64'd200;
        wait_done(n);
        chk("b2b_lat", 64'(n), 64'(W));
        chk("b2b_res1", result, 64'd3);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_nogap", 64'({busy, done}), 64'b10);
        wait_done(n);
        chk("b2b_lat2", 64'(n), 64'(W));
        chk("b2b_res2", result, 64'hAC);

        // reset while the slice is on bit 30
        start_op(3'b010, 64'h123, 64'h456);
        repeat (30) @(posedge clk);
        #1;
        chk("abort_busy_pre", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("abort_ctl", 64'({busy, done}), 64'd0);
        chk("abort_res", result, 64'd0);
        chk("abort_flags", 64'({negative, zero, overflow, carry_out}), 64'b0100);
        chk("abort_slice", 64'({slice_sel, slice_a, slice_b, slice_cin}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        chk("abort_nodone", 64'(dn), 64'd0);
        do_op("post_abort", 3'b010, 64'h123, 64'h456, 64'h579,
              1'b0, 1'b0, 1'b0, 1'b0);

        do_op("illegal", 3'b111, '1, '1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
